// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI master sequencing controller:
// FSM state encoding, transfer geometry and the CPHA edge-role decode.
package spi_ctrl_pkg;

  localparam int unsigned SPI_BITS  = 8;
  localparam int unsigned SPI_EDGES = 2 * SPI_BITS;
  localparam int unsigned EDGE_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_TAIL,
    ST_DONE
  } spi_state_e;

  // edge_n is 1-based: odd edges lead, even edges trail.
  function automatic logic sample_on_edge(input logic cpha, input logic [EDGE_W-1:0] edge_n);
    return cpha ? ~edge_n[0] : edge_n[0];
  endfunction

  // No shift on the first CPHA=1 edge (MOSI already valid from the load)
  // and none on the final CPHA=0 edge.
  function automatic logic shift_on_edge(input logic cpha, input logic [EDGE_W-1:0] edge_n);
    if (cpha) begin
      return edge_n[0] && (edge_n >= EDGE_W'(3));
    end
    return ~edge_n[0] && (edge_n <= EDGE_W'(SPI_EDGES - 2));
  endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period counter for the SPI serial clock: pulses tick once every div+1
// cycles while run is high, and restarts from zero whenever run drops.
module spi_baud_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Compare before incrementing so div = all-ones never wraps the counter.
  always_comb begin
    tick  = run && (cnt_q == div);
    cnt_d = cnt_q;
    if (!run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencing controller: turns a start pulse into one 8-bit transfer,
// generating ss_n/sclk and the load/shift/sample strobes for the shift register.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             start,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             ss_n,
  output logic             load_tx_reg,
  output logic             enable,
  output logic             shift_event,
  output logic             sample_event,
  output logic             busy,
  output logic             done
);

  spi_state_e        state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] ecnt_q, ecnt_d;
  logic [EDGE_W-1:0] edge_n;
  logic              sclk_q, sclk_d;
  logic              ss_n_q, ss_n_d;
  logic              load_q, load_d;
  logic              enable_q, enable_d;
  logic              shift_q, shift_d;
  logic              sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              run;
  logic              tick;

  assign run = (state_q == ST_XFER) || (state_q == ST_TAIL);

  spi_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .run    (run),
    .div    (div_q),
    .tick   (tick)
  );

  // Outputs are registered from the current state, so every output lags the
  // state register by one cycle and no input reaches an output combinationally.
  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    ecnt_d   = ecnt_q;
    sclk_d   = sclk_q;
    edge_n   = ecnt_q + EDGE_W'(1);
    busy_d   = (state_q == ST_LOAD) || (state_q == ST_XFER) || (state_q == ST_TAIL);
    ss_n_d   = ~busy_d;
    load_d   = (state_q == ST_LOAD);
    enable_d = (state_q == ST_XFER);
    done_d   = (state_q == ST_DONE);
    shift_d  = 1'b0;
    sample_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        ecnt_d = '0;
        if (start) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = div;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ecnt_d  = '0;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          sclk_d   = ~sclk_q;
          ecnt_d   = edge_n;
          sample_d = sample_on_edge(cpha_q, edge_n);
          shift_d  = shift_on_edge(cpha_q, edge_n);
          if (edge_n == EDGE_W'(SPI_EDGES)) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (tick) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      ecnt_q   <= '0;
      sclk_q   <= 1'b0;
      ss_n_q   <= 1'b1;
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      ecnt_q   <= ecnt_d;
      sclk_q   <= sclk_d;
      ss_n_q   <= ss_n_d;
      load_q   <= load_d;
      enable_q <= enable_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk         = sclk_q;
  assign ss_n         = ss_n_q;
  assign load_tx_reg  = load_q;
  assign enable       = enable_q;
  assign shift_event  = shift_q;
  assign sample_event = sample_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural shift register in loopback.
module tb_spi_master_ctrl;

  logic       PCLK;
  logic       PRESET;
  logic       start;
  logic       cpol;
  logic       cpha;
  logic [7:0] div;
  logic       sclk;
  logic       ss_n;
  logic       load_tx_reg;
  logic       enable;
  logic       shift_event;
  logic       sample_event;
  logic       busy;
  logic       done;

  int unsigned n_checks;
  int unsigned n_fail;

  logic       lsbfe;
  logic [7:0] tx_data_in;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       mosi;
  logic       miso;

  spi_master_ctrl #(
    .DIV_W (8)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .start        (start),
    .cpol         (cpol),
    .cpha         (cpha),
    .div          (div),
    .sclk         (sclk),
    .ss_n         (ss_n),
    .load_tx_reg  (load_tx_reg),
    .enable       (enable),
    .shift_event  (shift_event),
    .sample_event (sample_event),
    .busy         (busy),
    .done         (done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Shift register stand-in: MISO looped back to MOSI.
  assign mosi = lsbfe ? tx_sr[0] : tx_sr[7];
  assign miso = mosi;

  always @(posedge PCLK) begin
    if (load_tx_reg) begin
      tx_sr <= tx_data_in;
      rx_sr <= 8'h00;
    end else begin
      if (shift_event) tx_sr <= lsbfe ? (tx_sr >> 1) : (tx_sr << 1);
      if (sample_event) rx_sr <= lsbfe ? {miso, rx_sr[7:1]} : {rx_sr[6:0], miso};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] out_vec();
    return {sclk, ss_n, load_tx_reg, enable, shift_event, sample_event, busy, done};
  endfunction

  // Drives start after an edge (edge 0 samples it), scrambles the config inputs
  // afterwards, and checks every output in each cycle through the DONE cycle.
  task automatic run_xfer(input string name, input logic cp, input logic ch,
                          input logic [7:0] dv, input bit noise,
                          input logic lsb, input logic [7:0] txd);
    int t;
    int last;
    int e;
    int ne;
    bit is_edge;
    logic [7:0] exp;
    t    = int'(dv) + 1;
    last = 17 * t + 2;
    cpol = cp; cpha = ch; div = dv; lsbfe = lsb; tx_data_in = txd;
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    cpol = ~cp; cpha = ~ch; div = ~dv;
    for (int k = 1; k <= last; k++) begin
      @(posedge PCLK); #1;
      e       = (k - 1) / t;
      is_edge = (k >= 1 + t) && ((k - 1) % t == 0) && (e <= 16);
      ne      = (k >= 1 + t) ? ((e > 16) ? 16 : e) : 0;
      exp[7] = cp ^ ne[0];
      exp[6] = !(k <= 17 * t + 1);
      exp[5] = (k == 1);
      exp[4] = (k >= 2) && (k <= 16 * t + 1);
      exp[3] = is_edge && (ch ? (e % 2 == 1 && e >= 3) : (e % 2 == 0 && e <= 14));
      exp[2] = is_edge && (ch ? (e % 2 == 0) : (e % 2 == 1));
      exp[1] = (k <= 17 * t + 1);
      exp[0] = (k == last);
      check($sformatf("%s cyc%0d {sclk,ss_n,ld,en,sh,sa,busy,done}", name, k),
            32'(out_vec()), 32'(exp));
      if (k == last) check($sformatf("%s rx_data", name), 32'(rx_sr), 32'(txd));
      start = (noise && k >= 2 && k <= 17 * t + 1) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    cpol = cp; cpha = ch; div = dv;
  endtask

  initial begin
    int done_seen;
    n_checks = 0; n_fail = 0;
    PRESET = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0; div = 8'd0;
    lsbfe = 1'b0; tx_data_in = 8'h00;
    repeat (3) @(posedge PCLK);
    #1;
    check("reset outputs", 32'(out_vec()), 32'(8'b0100_0000));
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("idle sclk follows cpol=1", 32'(sclk), 32'(1'b1));
    check("idle ss_n", 32'(ss_n), 32'(1'b1));

    run_xfer("m0_div0", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'hA5);
    run_xfer("m3_div3", 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 8'h3C);

    for (int m = 0; m < 4; m++) begin
      for (int l = 0; l < 2; l++) begin
        run_xfer($sformatf("loop_m%0d_lsb%0d", m, l), m[1], m[0], 8'd1, 1'b0, l[0], 8'hA5);
      end
    end

    // Start held high through XFER/TAIL/DONE, then a back-to-back transfer.
    run_xfer("noise_start", 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 8'h5A);
    run_xfer("after_noise", 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'hC3);

    // Abort at the edge where SCLK edge 9 would occur (div=1 -> cycle 19).
    cpol = 1'b1; cpha = 1'b0; div = 8'd1; lsbfe = 1'b0; tx_data_in = 8'hA5;
    repeat (2) @(posedge PCLK);
    #1;
    start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge PCLK); #1;
    end
    check("pre-abort busy", 32'(busy), 32'(1'b1));
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("abort ss_n", 32'(ss_n), 32'(1'b1));
    check("abort sclk", 32'(sclk), 32'(1'b0));
    check("abort busy", 32'(busy), 32'(1'b0));
    check("abort done", 32'(done), 32'(1'b0));
    PRESET = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge PCLK); #1;
      if (done) done_seen++;
    end
    check("no done after abort", 32'(done_seen), 32'(0));
    run_xfer("post_abort", 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 8'hA5);

    run_xfer("div255", 1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
